// File: rtl/serial_add_pkg.sv
// serial_add_pkg: state encoding and default width shared by the serial adder
package serial_add_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
  localparam int DEF_WIDTH = 8;
endpackage

// File: rtl/full_adder_cell.sv
// full_adder_cell: one-bit combinational full adder
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: LSB-first bit-serial adder, one bit per clock, registered sum/cout with done pulse
module serial_adder_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  state_t state, state_d;
  logic [WIDTH-1:0] a_sr, b_sr, s_sr, a_sr_d, b_sr_d, s_sr_d, sum_d;
  logic [CW-1:0] cnt, cnt_d;
  logic carry, carry_d, cout_d, busy_d, done_d, fa_s, fa_c, accept;
  full_adder_cell u_fa (.a(a_sr[0]), .b(b_sr[0]), .cin(carry), .s(fa_s), .cout(fa_c));
  assign accept = start && (state == IDLE || state == DONE);
  always_comb begin
    state_d = state;
    a_sr_d = a_sr;
    b_sr_d = b_sr;
    s_sr_d = s_sr;
    carry_d = carry;
    cnt_d = cnt;
    sum_d = sum;
    cout_d = cout;
    busy_d = busy;
    done_d = 1'b0;
    if (accept) begin
      state_d = SHIFT;
      a_sr_d = a;
      b_sr_d = b;
      carry_d = cin;
      cnt_d = '0;
      busy_d = 1'b1;
    end else if (state == SHIFT) begin
      a_sr_d = a_sr >> 1;
      b_sr_d = b_sr >> 1;
      s_sr_d = {fa_s, s_sr[WIDTH-1:1]};
      carry_d = fa_c;
      cnt_d = (cnt == LAST) ? cnt : cnt + 1'b1;
      if (cnt == LAST) begin
        sum_d = s_sr_d;
        cout_d = fa_c;
        done_d = 1'b1;
        busy_d = 1'b0;
        state_d = DONE;
      end
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a_sr <= '0;
      b_sr <= '0;
      s_sr <= '0;
      carry <= 1'b0;
      cnt <= '0;
      sum <= '0;
      cout <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_d;
      a_sr <= a_sr_d;
      b_sr <= b_sr_d;
      s_sr <= s_sr_d;
      carry <= carry_d;
      cnt <= cnt_d;
      sum <= sum_d;
      cout <= cout_d;
      busy <= busy_d;
      done <= done_d;
    end
  end
endmodule
